// File: rtl/nes_mem_arbiter.sv
// Cartridge memory arbiter: shares one external memory port between the PPU
// CHR fetch path, the CPU PRG path and the aux (loader / savestate) port.
// One access is in flight at a time. Fixed priority PPU > CPU > aux, with a
// grant counter that forces aux through after STARVE_MAX other grants.
module nes_mem_arbiter #(
  parameter int ADDR_W     = 22,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ppu_req,
  input  logic [ADDR_W-1:0] ppu_addr,
  output logic              ppu_busy,
  output logic              ppu_done,
  output logic [7:0]        ppu_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic [7:0]        cpu_rdata,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [7:0]        aux_wdata,
  output logic              aux_busy,
  output logic              aux_done,
  output logic [7:0]        aux_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  // Requester indices: bit 0 = PPU, bit 1 = CPU, bit 2 = aux.
  localparam logic [1:0] SEL_PPU    = 2'd0;
  localparam logic [1:0] SEL_CPU    = 2'd1;
  localparam logic [1:0] SEL_AUX    = 2'd2;
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [2:0]        req_s, we_s, cap_s, win_oh_s, done_oh_s;
  logic [2:0]        pend_v_next_s, svc_next_s;
  logic [ADDR_W-1:0] addr_s [3];
  logic [7:0]        wdata_s [3];
  logic [1:0]        win_s;
  logic              grant_s, ack_s;
  logic [7:0]        starve_next_s;

  state_t            state_r;
  logic [1:0]        sel_r;
  logic [2:0]        pend_v_r, pend_we_r, svc_r, busy_r, done_r;
  logic [ADDR_W-1:0] pend_addr_r [3];
  logic [7:0]        pend_wdata_r [3];
  logic [7:0]        rdata_r [3];
  logic [7:0]        starve_cnt_r;
  logic              mem_req_r, mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [7:0]        mem_wdata_r;

  assign req_s      = {aux_req, cpu_req, ppu_req};
  assign we_s       = {aux_we, cpu_we, 1'b0};
  assign addr_s[0]  = ppu_addr;
  assign addr_s[1]  = cpu_addr;
  assign addr_s[2]  = aux_addr;
  assign wdata_s[0] = 8'h00;
  assign wdata_s[1] = cpu_wdata;
  assign wdata_s[2] = aux_wdata;

  // A request is taken only while its requester has nothing outstanding.
  assign cap_s     = req_s & ~busy_r;
  assign grant_s   = (state_r == ST_IDLE) && (pend_v_r != 3'b000);
  assign ack_s     = (state_r == ST_WAIT) && mem_req_r && mem_ack;
  assign win_oh_s  = grant_s ? (3'b001 << win_s) : 3'b000;
  assign done_oh_s = ack_s ? (3'b001 << sel_r) : 3'b000;

  assign pend_v_next_s = (pend_v_r & ~win_oh_s) | cap_s;
  assign svc_next_s    = (svc_r & ~done_oh_s) | win_oh_s;

  // Pick the next winner: a starved aux overrides the fixed priority.
  always_comb begin
    win_s = SEL_PPU;
    if (pend_v_r[2] && (starve_cnt_r == STARVE_LIM)) begin
      win_s = SEL_AUX;
    end else if (pend_v_r[0]) begin
      win_s = SEL_PPU;
    end else if (pend_v_r[1]) begin
      win_s = SEL_CPU;
    end else if (pend_v_r[2]) begin
      win_s = SEL_AUX;
    end else begin
      win_s = SEL_PPU;
    end
  end

  // Count PPU/CPU grants that overtake a waiting aux request.
  always_comb begin
    starve_next_s = starve_cnt_r;
    if (grant_s && (win_s == SEL_AUX)) begin
      starve_next_s = 8'd0;
    end else if (!pend_v_r[2]) begin
      starve_next_s = 8'd0;
    end else if (grant_s && (starve_cnt_r != 8'hFF)) begin
      starve_next_s = starve_cnt_r + 8'd1;
    end else begin
      starve_next_s = starve_cnt_r;
    end
  end

  // Capture registers, arbitration FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      sel_r        <= SEL_PPU;
      pend_v_r     <= 3'b000;
      pend_we_r    <= 3'b000;
      svc_r        <= 3'b000;
      busy_r       <= 3'b000;
      done_r       <= 3'b000;
      starve_cnt_r <= 8'd0;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= 8'h00;
      for (int i = 0; i < 3; i++) begin
        pend_addr_r[i]  <= '0;
        pend_wdata_r[i] <= 8'h00;
        rdata_r[i]      <= 8'h00;
      end
    end else begin
      pend_v_r     <= pend_v_next_s;
      svc_r        <= svc_next_s;
      busy_r       <= pend_v_next_s | svc_next_s;
      done_r       <= done_oh_s;
      starve_cnt_r <= starve_next_s;
      for (int i = 0; i < 3; i++) begin
        if (cap_s[i]) begin
          pend_we_r[i]    <= we_s[i];
          pend_addr_r[i]  <= addr_s[i];
          pend_wdata_r[i] <= wdata_s[i];
        end
      end
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= pend_we_r[win_s];
            mem_addr_r  <= pend_addr_r[win_s];
            mem_wdata_r <= pend_wdata_r[win_s];
            sel_r       <= win_s;
            state_r     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (ack_s) begin
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
            if (!mem_we_r) begin
              rdata_r[sel_r] <= mem_rdata;
            end
            state_r <= ST_IDLE;
          end
        end
        default: begin
          mem_req_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign ppu_busy  = busy_r[0];
  assign cpu_busy  = busy_r[1];
  assign aux_busy  = busy_r[2];
  assign ppu_done  = done_r[0];
  assign cpu_done  = done_r[1];
  assign aux_done  = done_r[2];
  assign ppu_rdata = rdata_r[0];
  assign cpu_rdata = rdata_r[1];
  assign aux_rdata = rdata_r[2];
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_nes_mem_arbiter.sv
// Testbench for nes_mem_arbiter: memory responder model, per-port done
// scoreboard, a table of single accesses and hand-written corner sequences.
module tb_nes_mem_arbiter;
  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ppu_req = 1'b0, cpu_req = 1'b0, aux_req = 1'b0;
  logic          cpu_we = 1'b0, aux_we = 1'b0;
  logic [AW-1:0] ppu_addr = '0, cpu_addr = '0, aux_addr = '0;
  logic [7:0]    cpu_wdata = 8'h00, aux_wdata = 8'h00;
  logic          ppu_busy, cpu_busy, aux_busy, ppu_done, cpu_done, aux_done;
  logic [7:0]    ppu_rdata, cpu_rdata, aux_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_ack = 1'b0;
  logic [7:0]    mem_rdata = 8'h00;

  always #5 clk = ~clk;

  nes_mem_arbiter #(.ADDR_W(AW), .STARVE_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_busy(ppu_busy),
    .ppu_done(ppu_done), .ppu_rdata(ppu_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy), .cpu_done(cpu_done),
    .cpu_rdata(cpu_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
    .aux_wdata(aux_wdata), .aux_busy(aux_busy), .aux_done(aux_done),
    .aux_rdata(aux_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct { logic we; logic [7:0] data; } exp_t;
  typedef struct { logic we; logic [AW-1:0] addr; logic [7:0] wdata; } gnt_t;
  typedef struct {
    int port; logic we; logic [AW-1:0] addr; logic [7:0] wdata;
    logic pre_en; logic [7:0] pre; int dly; logic [7:0] exp_rd;
  } vec_t;

  exp_t       exp_q0[$], exp_q1[$], exp_q2[$];
  gnt_t       gnt_log[$];
  logic [7:0] mem_m [logic [AW-1:0]];
  logic [7:0] last_rd [3];
  int         done_cnt [3];
  int         errors = 0, checks = 0;
  int         ack_delay = 3;
  bit         resp_en = 1'b1;
  logic       man_ack = 1'b0;
  vec_t       vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] model_rd(input logic [AW-1:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a[7:0] ^ a[15:8] ^ 8'h96;
  endfunction

  function automatic logic [7:0] get_rdata(input int p);
    case (p)
      0: return ppu_rdata;
      1: return cpu_rdata;
      default: return aux_rdata;
    endcase
  endfunction

  function automatic logic get_done(input int p);
    case (p)
      0: return ppu_done;
      1: return cpu_done;
      default: return aux_done;
    endcase
  endfunction

  function automatic bit q_empty(input int p);
    case (p)
      0: return exp_q0.size() == 0;
      1: return exp_q1.size() == 0;
      default: return exp_q2.size() == 0;
    endcase
  endfunction

  task automatic push_exp(input int p, input exp_t e);
    case (p)
      0: exp_q0.push_back(e);
      1: exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int p, output exp_t e);
    case (p)
      0: e = exp_q0.pop_front();
      1: e = exp_q1.pop_front();
      default: e = exp_q2.pop_front();
    endcase
  endtask

  task automatic drive(input int p, input logic rq, input logic we,
                       input logic [AW-1:0] a, input logic [7:0] d);
    case (p)
      0: begin ppu_req = rq; ppu_addr = a; end
      1: begin cpu_req = rq; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
      default: begin aux_req = rq; aux_we = we; aux_addr = a; aux_wdata = d; end
    endcase
  endtask

  // Drive an accepted request and record what its done must carry.
  task automatic issue(input int p, input logic we, input logic [AW-1:0] a, input logic [7:0] d);
    exp_t e;
    drive(p, 1'b1, we, a, d);
    e.we   = we;
    e.data = we ? 8'h00 : model_rd(a);
    push_exp(p, e);
  endtask

  task automatic release_all();
    ppu_req = 1'b0;
    cpu_req = 1'b0;
    aux_req = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while (c < 300 && (ppu_busy || cpu_busy || aux_busy || mem_req ||
           !q_empty(0) || !q_empty(1) || !q_empty(2))) begin
      @(negedge clk);
      c++;
    end
    if (c >= 300) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: actual=busy required=idle");
    end
    @(negedge clk);
  endtask

  // Memory responder: logs each grant, acks after ack_delay cycles.
  int rcnt = 0;
  always @(negedge clk) begin
    if (!resp_en) begin
      rcnt = 0;
      mem_ack = man_ack;
      mem_rdata = 8'hEE;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      if (rcnt == 0) gnt_log.push_back('{mem_we, mem_addr, mem_wdata});
      if (rcnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = model_rd(mem_addr);
        if (mem_we) mem_m[mem_addr] = mem_wdata;
        rcnt = 0;
      end else begin
        rcnt++;
      end
    end
  end

  // Done scoreboard: one-hot, single-cycle pulses carrying the right data.
  logic [2:0] prev_done = 3'b000;
  always @(negedge clk) begin
    logic [2:0] dn;
    exp_t e;
    dn = {aux_done, cpu_done, ppu_done};
    if (!reset) begin
      if (dn != 3'b000) check("done_onehot", 64'($countones(dn) <= 1), 64'd1);
      for (int p = 0; p < 3; p++) begin
        if (dn[p]) begin
          check($sformatf("done_width_p%0d", p), 64'(prev_done[p]), 64'd0);
          if (q_empty(p)) begin
            checks++;
            errors++;
            $display("FAIL done_unexpected_p%0d: actual=done required=no_done", p);
          end else begin
            pop_exp(p, e);
            check($sformatf("rdata_p%0d", p), 64'(get_rdata(p)),
                  64'(e.we ? last_rd[p] : e.data));
            if (!e.we) last_rd[p] = e.data;
          end
          done_cnt[p]++;
        end
      end
    end
    prev_done = dn;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int gs, c0, c1, c2, hits, k0, k1;
    bit seen;
    vec_t v;
    for (int p = 0; p < 3; p++) begin last_rd[p] = 8'h00; done_cnt[p] = 0; end

    vecs[0] = '{0, 1'b0, 22'h001234, 8'h00, 1'b1, 8'h11, 1, 8'h11};
    vecs[1] = '{1, 1'b0, 22'h3FFFFF, 8'h00, 1'b1, 8'hFF, 2, 8'hFF};
    vecs[2] = '{2, 1'b0, 22'h3C0010, 8'h00, 1'b1, 8'h77, 1, 8'h77};
    vecs[3] = '{2, 1'b1, 22'h3C0010, 8'hA5, 1'b0, 8'h00, 4, 8'h77};
    vecs[4] = '{2, 1'b0, 22'h3C0010, 8'h00, 1'b0, 8'h00, 2, 8'hA5};
    vecs[5] = '{1, 1'b1, 22'h000000, 8'h00, 1'b0, 8'h00, 1, 8'hFF};
    vecs[6] = '{1, 1'b0, 22'h000000, 8'h00, 1'b0, 8'h00, 3, 8'h00};
    vecs[7] = '{0, 1'b0, 22'h2AAAAA, 8'h00, 1'b1, 8'h3C, 5, 8'h3C};

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_outputs", {mem_req, mem_we, mem_addr, mem_wdata, ppu_busy, cpu_busy,
          aux_busy, ppu_done, cpu_done, aux_done, ppu_rdata, cpu_rdata, aux_rdata}, 64'd0);

    // Single CPU read with cycle-exact latency
    mem_m[22'h03C123] = 8'h5A;
    ack_delay = 3;
    issue(1, 1'b0, 22'h03C123, 8'h00);
    @(negedge clk);
    release_all();
    check("t1_busy_after_req", {cpu_busy, mem_req}, 64'b10);
    @(negedge clk);
    check("t1_mem_fields", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 22'h03C123});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t1_waiting", {cpu_busy, cpu_done, mem_req}, 64'b101);
    end
    @(negedge clk);
    check("t1_done", {cpu_done, cpu_busy, mem_req}, 64'b100);
    check("t1_rdata", 64'(cpu_rdata), 64'h5A);
    @(negedge clk);
    check("t1_done_pulse", 64'(cpu_done), 64'd0);

    // Table of isolated accesses
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      wait_idle();
      ack_delay = v.dly;
      if (v.pre_en) mem_m[v.addr] = v.pre;
      issue(v.port, v.we, v.addr, v.wdata);
      @(negedge clk);
      release_all();
      seen = 1'b0;
      for (int c = 0; c < 60; c++) begin
        if (mem_req) begin
          if (v.we) check($sformatf("vec%0d_mem", i), {mem_we, mem_addr, mem_wdata},
                          {1'b1, v.addr, v.wdata});
          else check($sformatf("vec%0d_mem", i), {mem_we, mem_addr}, {1'b0, v.addr});
        end
        if (get_done(v.port)) begin
          seen = 1'b1;
          check($sformatf("vec%0d_rdata", i), 64'(get_rdata(v.port)), 64'(v.exp_rd));
          break;
        end
        @(negedge clk);
      end
      if (!seen) begin
        checks++;
        errors++;
        $display("FAIL vec%0d_timeout: actual=no_done required=done", i);
      end
    end

    // Simultaneous requests from all three ports
    wait_idle();
    ack_delay = 1;
    gs = gnt_log.size();
    c0 = done_cnt[0]; c1 = done_cnt[1]; c2 = done_cnt[2];
    issue(0, 1'b0, 22'h011111, 8'h00);
    issue(1, 1'b0, 22'h022222, 8'h00);
    issue(2, 1'b0, 22'h033333, 8'h00);
    @(negedge clk);
    release_all();
    wait_idle();
    check("t2_grants", 64'(gnt_log.size() - gs), 64'd3);
    check("t2_order0", 64'(gnt_log[gs].addr), 64'h011111);
    check("t2_order1", 64'(gnt_log[gs+1].addr), 64'h022222);
    check("t2_order2", 64'(gnt_log[gs+2].addr), 64'h033333);
    check("t2_dones", {8'(done_cnt[0]-c0), 8'(done_cnt[1]-c1), 8'(done_cnt[2]-c2)}, 64'h010101);

    // Aux starvation guard
    gs = gnt_log.size();
    c2 = done_cnt[2];
    k0 = 0; k1 = 0;
    for (int cyc = 0; cyc < 400 && done_cnt[2] == c2; cyc++) begin
      if (!ppu_busy) begin issue(0, 1'b0, 22'h100000 + 22'(k0), 8'h00); k0++; end
      else drive(0, 1'b0, 1'b0, 22'h000000, 8'h00);
      if (!cpu_busy) begin issue(1, 1'b0, 22'h200000 + 22'(k1), 8'h00); k1++; end
      else drive(1, 1'b0, 1'b0, 22'h000000, 8'h00);
      if (cyc == 0) issue(2, 1'b0, 22'h3C0000, 8'h00);
      else drive(2, 1'b0, 1'b0, 22'h000000, 8'h00);
      @(negedge clk);
    end
    release_all();
    check("t3_aux_done", 64'(done_cnt[2] - c2), 64'd1);
    wait_idle();
    hits = 0;
    for (int i = 0; i < 8; i++) if (gnt_log[gs+i].addr == 22'h3C0000) hits++;
    check("t3_first8_not_aux", 64'(hits), 64'd0);
    check("t3_ninth_is_aux", 64'(gnt_log[gs+8].addr), 64'h3C0000);
    check("t3_starve_cleared", 64'(dut.starve_cnt_r), 64'd0);

    // Request while busy is ignored
    gs = gnt_log.size();
    c1 = done_cnt[1];
    issue(1, 1'b0, 22'h055555, 8'h00);
    @(negedge clk);
    check("t4_busy", 64'(cpu_busy), 64'd1);
    drive(1, 1'b1, 1'b0, 22'h0AAAAA, 8'h00);
    @(negedge clk);
    release_all();
    wait_idle();
    check("t4_one_grant", 64'(gnt_log.size() - gs), 64'd1);
    check("t4_addr", 64'(gnt_log[gs].addr), 64'h055555);
    check("t4_one_done", 64'(done_cnt[1] - c1), 64'd1);

    // Reset during WAIT, then a stray ack
    resp_en = 1'b0;
    c1 = done_cnt[1];
    issue(1, 1'b0, 22'h012345, 8'h00);
    @(negedge clk);
    release_all();
    @(negedge clk);
    check("t5_in_wait", 64'(mem_req), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q1.delete();
    for (int p = 0; p < 3; p++) last_rd[p] = 8'h00;
    check("t5_after_reset", {mem_req, ppu_busy, cpu_busy, aux_busy, ppu_done, cpu_done,
          aux_done, ppu_rdata, cpu_rdata, aux_rdata}, 64'd0);
    @(negedge clk);
    man_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    man_ack = 1'b0;
    check("t5_no_done", {cpu_done, mem_req, cpu_busy}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("t5_still_quiet", {cpu_done, mem_req, cpu_rdata}, 64'd0);
    check("t5_no_done_count", 64'(done_cnt[1] - c1), 64'd0);
    resp_en = 1'b1;
    ack_delay = 2;
    gs = gnt_log.size();
    issue(1, 1'b0, 22'h012345, 8'h00);
    @(negedge clk);
    release_all();
    wait_idle();
    check("t5_recover_addr", 64'(gnt_log[gs].addr), 64'h012345);
    check("t5_recover_done", 64'(done_cnt[1] - c1), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
